echo_ranger: RTL and testbench

Drives an ultrasonic ranging sensor (trigger-pulse / echo-width protocol) and converts echo width into the 13-bit millimetre distance consumed by the distance-to-amplitude scaler ahead of the NCO output. This block is the producing end of that `distance` bus. It fires periodic trigger pulses, times the returned echo in microseconds, and scales the result to mm. It publishes a held distance word with a one-cycle valid strobe, and flags timeouts.

---
 rtl/ranger_pkg.sv | 28 ++
 rtl/echo_sync.sv | 41 ++++
 rtl/echo_ranger.sv | 177 +++++++++++++++++
 tb/tb_echo_ranger.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ranger_pkg.sv
// Shared types and constants for the ultrasonic echo ranger.
// Holds the measurement FSM state type, the distance/echo widths, the
// "no valid reading" distance code and the us-to-mm conversion helper.
package ranger_pkg;

   typedef enum logic [2:0] {
      IDLE,
      TRIG,
      WAIT_RISE,
      MEASURE,
      CONVERT
   } ranger_state_t;

   localparam int unsigned         DIST_W   = 13;
   localparam logic [DIST_W-1:0]   DIST_SAT = 13'h1FFF;
   localparam int unsigned         ECHO_W   = 15;

   // Echo width in us times the Q0.16 factor gives mm in bits [28:16].
   // A 13-bit slice of the 29-bit product tops out at 8191, which is the
   // saturation value, so no separate clamp is needed.
   function automatic logic [DIST_W-1:0] us_to_mm(input logic [ECHO_W-1:0] us,
                                                 input logic [13:0]       scale);
      logic [28:0] prod;
      prod = 29'(us) * 29'(scale);
      return prod[28:16];
   endfunction

endpackage

// File: rtl/echo_sync.sv
// Echo input conditioner.
// Two-flop synchronizer for the asynchronous echo line followed by a
// registered edge detector. Rise and fall pulses share the same latency, so
// the distance between them equals the true echo width in clock cycles.
// Ports:
//   clk_i   - system clock
//   reset_i - asynchronous active-high reset
//   echo_i  - raw sensor echo
//   rise_o  - one-cycle pulse on a synchronized rising edge
//   fall_o  - one-cycle pulse on a synchronized falling edge
module echo_sync (
   input  logic clk_i,
   input  logic reset_i,
   input  logic echo_i,
   output logic rise_o,
   output logic fall_o
);

   logic s1_q, s2_q, s3_q;
   logic rise_q, fall_q;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         s3_q   <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         s1_q   <= echo_i;
         s2_q   <= s1_q;
         s3_q   <= s2_q;
         rise_q <= s2_q & ~s3_q;
         fall_q <= ~s2_q & s3_q;
      end
   end

   assign rise_o = rise_q;
   assign fall_o = fall_q;

endmodule

// File: rtl/echo_ranger.sv
// Ultrasonic ranging sensor driver.
// Fires a periodic trigger pulse, times the returned echo in microseconds
// and converts it to a 13-bit millimetre distance. The distance word is held
// between updates; valid_o strobes with each new reading and timeout_o
// strobes (with distance forced to 8191) when no usable echo arrives.
// Ports:
//   clk_i      - system clock, CLK_MHZ cycles per microsecond
//   reset_i    - asynchronous active-high reset
//   enable_i   - run periodic measurements while high
//   echo_i     - sensor echo, asynchronous to clk_i
//   trig_o     - sensor trigger pulse
//   distance_o - last measured distance in mm
//   valid_o    - one-cycle strobe when distance_o updates
//   timeout_o  - one-cycle strobe when a measurement timed out
//   busy_o     - high from trigger start until the measurement ends
module echo_ranger
   import ranger_pkg::*;
#(
   parameter int unsigned CLK_MHZ    = 50,
   parameter int unsigned TRIG_US    = 10,
   parameter int unsigned PERIOD_US  = 60000,
   parameter int unsigned TIMEOUT_US = 24000,
   parameter int unsigned SCALE      = 11239
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              enable_i,
   input  logic              echo_i,
   output logic              trig_o,
   output logic [DIST_W-1:0] distance_o,
   output logic              valid_o,
   output logic              timeout_o,
   output logic              busy_o
);

   localparam int unsigned PreW  = $clog2(CLK_MHZ);
   localparam int unsigned PerW  = $clog2(PERIOD_US);
   localparam int unsigned TrigW = $clog2(TRIG_US * CLK_MHZ);

   localparam logic [PreW-1:0]   PreMax  = PreW'(CLK_MHZ - 1);
   localparam logic [PerW-1:0]   PerMax  = PerW'(PERIOD_US - 1);
   localparam logic [TrigW-1:0]  TrigMax = TrigW'(TRIG_US * CLK_MHZ - 1);
   localparam logic [ECHO_W-1:0] ToUs    = ECHO_W'(TIMEOUT_US);
   localparam logic [13:0]       ScaleQ  = 14'(SCALE);

   ranger_state_t     state_q, state_d;
   logic [PreW-1:0]   per_pre_q, per_pre_d;
   logic [PerW-1:0]   per_cnt_q, per_cnt_d;
   logic [TrigW-1:0]  trig_cnt_q, trig_cnt_d;
   logic [PreW-1:0]   meas_pre_q, meas_pre_d;
   logic [ECHO_W-1:0] us_q, us_d;
   logic [DIST_W-1:0] distance_q, distance_d;
   logic              valid_q, valid_d;
   logic              timeout_q, timeout_d;

   logic echo_rise, echo_fall;
   logic per_tick, meas_tick;

   echo_sync u_echo_sync (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .echo_i  (echo_i),
      .rise_o  (echo_rise),
      .fall_o  (echo_fall)
   );

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= IDLE;
         per_pre_q  <= '0;
         per_cnt_q  <= '0;
         trig_cnt_q <= '0;
         meas_pre_q <= '0;
         us_q       <= '0;
         distance_q <= DIST_SAT;
         valid_q    <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         per_pre_q  <= per_pre_d;
         per_cnt_q  <= per_cnt_d;
         trig_cnt_q <= trig_cnt_d;
         meas_pre_q <= meas_pre_d;
         us_q       <= us_d;
         distance_q <= distance_d;
         valid_q    <= valid_d;
         timeout_q  <= timeout_d;
      end
   end

   assign per_tick  = enable_i && (per_pre_q == PreMax);
   assign meas_tick = (meas_pre_q == PreMax);

   always_comb begin
      state_d    = state_q;
      per_pre_d  = per_pre_q;
      per_cnt_d  = per_cnt_q;
      trig_cnt_d = trig_cnt_q;
      meas_pre_d = meas_pre_q;
      us_d       = us_q;
      distance_d = distance_q;
      valid_d    = 1'b0;
      timeout_d  = 1'b0;

      // Period timebase free-runs only while enabled, so the first trigger
      // lands a full period after enable rises.
      if (!enable_i) begin
         per_pre_d = '0;
         per_cnt_d = '0;
      end else if (per_tick) begin
         per_pre_d = '0;
         per_cnt_d = (per_cnt_q == PerMax) ? '0 : per_cnt_q + 1'b1;
      end else begin
         per_pre_d = per_pre_q + 1'b1;
      end

      unique case (state_q)
         IDLE: begin
            if (per_tick && (per_cnt_q == PerMax)) begin
               state_d    = TRIG;
               trig_cnt_d = '0;
            end
         end
         TRIG: begin
            // Measure timebase starts from zero when WAIT_RISE is entered.
            meas_pre_d = '0;
            us_d       = '0;
            if (trig_cnt_q == TrigMax) begin
               state_d = WAIT_RISE;
            end else begin
               trig_cnt_d = trig_cnt_q + 1'b1;
            end
         end
         WAIT_RISE: begin
            if (us_q == ToUs) begin
               state_d    = IDLE;
               timeout_d  = 1'b1;
               distance_d = DIST_SAT;
            end else if (echo_rise) begin
               state_d    = MEASURE;
               meas_pre_d = '0;
               us_d       = '0;
            end else begin
               meas_pre_d = meas_tick ? '0 : meas_pre_q + 1'b1;
               us_d       = meas_tick ? us_q + 1'b1 : us_q;
            end
         end
         MEASURE: begin
            if (us_q == ToUs) begin
               state_d    = IDLE;
               timeout_d  = 1'b1;
               distance_d = DIST_SAT;
            end else begin
               // The fall cycle still counts so the width spans rise..fall.
               meas_pre_d = meas_tick ? '0 : meas_pre_q + 1'b1;
               us_d       = meas_tick ? us_q + 1'b1 : us_q;
               if (echo_fall) begin
                  state_d = CONVERT;
               end
            end
         end
         CONVERT: begin
            distance_d = us_to_mm(us_q, ScaleQ);
            valid_d    = 1'b1;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign trig_o     = (state_q == TRIG);
   assign busy_o     = (state_q != IDLE);
   assign distance_o = distance_q;
   assign valid_o    = valid_q;
   assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_echo_ranger.sv
// Directed self-checking bench for echo_ranger, scaled down to
// CLK_MHZ=2, PERIOD_US=3000, TIMEOUT_US=1400 so runs stay short.
// Distances: 1000 us -> 171 mm, 400 us -> 68 mm, 1234 us -> 211 mm
// (floor(us * 11239 / 65536)).
module tb_echo_ranger;

   localparam int unsigned CLK_MHZ    = 2;
   localparam int unsigned TRIG_US    = 10;
   localparam int unsigned PERIOD_US  = 3000;
   localparam int unsigned TIMEOUT_US = 1400;
   localparam int PC  = 6000;  // period in cycles
   localparam int TC  = 20;    // trigger width in cycles
   localparam int TOC = 2800;  // timeout in cycles

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic        echo = 1'b0;
   logic        trig, valid, timeout, busy;
   logic [12:0] distance;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int last_rise = 0;

   echo_ranger #(
      .CLK_MHZ    (CLK_MHZ),
      .TRIG_US    (TRIG_US),
      .PERIOD_US  (PERIOD_US),
      .TIMEOUT_US (TIMEOUT_US),
      .SCALE      (11239)
   ) dut (
      .clk_i      (clk),
      .reset_i    (reset),
      .enable_i   (enable),
      .echo_i     (echo),
      .trig_o     (trig),
      .distance_o (distance),
      .valid_o    (valid),
      .timeout_o  (timeout),
      .busy_o     (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic wait_trig_rise(input int budget, output bit ok, output int at);
      ok = 1'b0;
      at = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (trig === 1'b1) begin
            ok = 1'b1;
            at = cyc;
            break;
         end
      end
   endtask

   // Called at the negedge where trig was first seen high.
   task automatic wait_trig_fall(input int budget, output bit ok, output int width);
      ok = 1'b0;
      width = 1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (trig === 1'b0) begin
            ok = 1'b1;
            break;
         end
         width++;
      end
   endtask

   task automatic wait_result(input int budget, output bit got_v, output bit got_t,
                              output logic [12:0] d, output int at);
      got_v = 1'b0;
      got_t = 1'b0;
      d = 'x;
      at = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (valid === 1'b1 || timeout === 1'b1) begin
            got_v = (valid === 1'b1);
            got_t = (timeout === 1'b1);
            d = distance;
            at = cyc;
            break;
         end
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (trig !== 1'b0) begin errors++; $display("FAIL reset_trig: got %b want 0", trig); end
      checks++; if (distance !== 13'h1FFF) begin errors++; $display("FAIL reset_distance: got %0d want 8191", distance); end
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
      checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", timeout); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      reset = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_first_measure;
      bit ok, gv, gt;
      int at, w, c0;
      logic [12:0] d;
      @(negedge clk);
      enable = 1'b1;
      c0 = cyc;
      wait_trig_rise(PC + 20, ok, at);
      checks++; if (!ok || at - c0 != PC) begin errors++; $display("FAIL first_trig_delay: got %0d want %0d (seen=%0b)", at - c0, PC, ok); end
      last_rise = at;
      wait_trig_fall(100, ok, w);
      checks++; if (!ok || w != TC) begin errors++; $display("FAIL trig_width: got %0d want %0d", w, TC); end
      echo = 1'b1;
      repeat (1000) @(negedge clk);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_measure: got %b want 1", busy); end
      repeat (1000) @(negedge clk);
      echo = 1'b0;
      wait_result(50, gv, gt, d, at);
      checks++; if (!gv) begin errors++; $display("FAIL m1000_valid: got %b want 1", gv); end
      checks++; if (gt) begin errors++; $display("FAIL m1000_timeout: got %b want 0", gt); end
      checks++; if (d !== 13'd171) begin errors++; $display("FAIL m1000_distance: got %0d want 171", d); end
      @(negedge clk);
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL valid_one_cycle: got %b want 0", valid); end
      checks++; if (distance !== 13'd171) begin errors++; $display("FAIL distance_held: got %0d want 171", distance); end
   endtask

   task automatic test_back_to_back;
      bit ok, gv, gt;
      int at, w;
      logic [12:0] d;
      wait_trig_rise(PC + 20, ok, at);
      checks++; if (!ok || at - last_rise != PC) begin errors++; $display("FAIL b2b_spacing: got %0d want %0d", at - last_rise, PC); end
      last_rise = at;
      wait_trig_fall(100, ok, w);
      checks++; if (!ok || w != TC) begin errors++; $display("FAIL b2b_trig_width: got %0d want %0d", w, TC); end
      repeat (5) @(negedge clk);
      echo = 1'b1;
      repeat (800) @(negedge clk);
      echo = 1'b0;
      wait_result(50, gv, gt, d, at);
      checks++; if (!gv) begin errors++; $display("FAIL m400_valid: got %b want 1", gv); end
      checks++; if (d !== 13'd68) begin errors++; $display("FAIL m400_distance: got %0d want 68", d); end
   endtask

   task automatic test_no_echo;
      bit ok, gv, gt;
      int at, w, f;
      logic [12:0] d;
      wait_trig_rise(PC + 20, ok, at);
      checks++; if (!ok || at - last_rise != PC) begin errors++; $display("FAIL noecho_spacing: got %0d want %0d", at - last_rise, PC); end
      last_rise = at;
      wait_trig_fall(100, ok, w);
      f = cyc;
      wait_result(TOC + 100, gv, gt, d, at);
      checks++; if (!gt) begin errors++; $display("FAIL noecho_timeout: got %b want 1", gt); end
      checks++; if (gv) begin errors++; $display("FAIL noecho_valid: got %b want 0", gv); end
      checks++; if (at - f < TOC || at - f > TOC + 4) begin errors++; $display("FAIL noecho_delay: got %0d want %0d..%0d", at - f, TOC, TOC + 4); end
      checks++; if (d !== 13'h1FFF) begin errors++; $display("FAIL noecho_distance: got %0d want 8191", d); end
   endtask

   task automatic test_stuck_high;
      bit ok, gv, gt;
      int at, w, e;
      logic [12:0] d;
      wait_trig_rise(PC + 20, ok, at);
      checks++; if (!ok || at - last_rise != PC) begin errors++; $display("FAIL stuck_spacing: got %0d want %0d", at - last_rise, PC); end
      last_rise = at;
      wait_trig_fall(100, ok, w);
      repeat (10) @(negedge clk);
      echo = 1'b1;
      e = cyc;
      wait_result(TOC + 100, gv, gt, d, at);
      checks++; if (!gt) begin errors++; $display("FAIL stuck_timeout: got %b want 1", gt); end
      checks++; if (gv) begin errors++; $display("FAIL stuck_valid: got %b want 0", gv); end
      checks++; if (at - e < TOC || at - e > TOC + 10) begin errors++; $display("FAIL stuck_delay: got %0d want %0d..%0d", at - e, TOC, TOC + 10); end
      checks++; if (d !== 13'h1FFF) begin errors++; $display("FAIL stuck_distance: got %0d want 8191", d); end
      repeat (100) @(negedge clk);
      echo = 1'b0;
      wait_trig_rise(PC + 20, ok, at);
      checks++; if (!ok || at - last_rise != PC) begin errors++; $display("FAIL after_stuck_spacing: got %0d want %0d", at - last_rise, PC); end
      last_rise = at;
   endtask

   task automatic test_reset_mid_measure;
      bit ok;
      int at, w, c0;
      wait_trig_fall(100, ok, w);
      echo = 1'b1;
      repeat (100) @(negedge clk);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL pre_reset_busy: got %b want 1", busy); end
      #2 reset = 1'b1;
      #1;
      checks++; if (trig !== 1'b0) begin errors++; $display("FAIL async_trig: got %b want 0", trig); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_busy: got %b want 0", busy); end
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL async_valid: got %b want 0", valid); end
      checks++; if (distance !== 13'h1FFF) begin errors++; $display("FAIL async_distance: got %0d want 8191", distance); end
      echo = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      c0 = cyc;
      wait_trig_rise(PC + 20, ok, at);
      checks++; if (!ok || at - c0 != PC) begin errors++; $display("FAIL post_reset_trig: got %0d want %0d", at - c0, PC); end
      last_rise = at;
   endtask

   task automatic test_enable_drop;
      bit ok, gv, gt;
      int at, w, trig_seen;
      logic [12:0] d;
      wait_trig_fall(100, ok, w);
      echo = 1'b1;
      repeat (100) @(negedge clk);
      enable = 1'b0;
      repeat (2368) @(negedge clk);
      echo = 1'b0;
      wait_result(50, gv, gt, d, at);
      checks++; if (!gv) begin errors++; $display("FAIL drop_valid: got %b want 1", gv); end
      checks++; if (d !== 13'd211) begin errors++; $display("FAIL drop_distance: got %0d want 211", d); end
      trig_seen = 0;
      for (int i = 0; i < PC + 1000; i++) begin
         @(negedge clk);
         if (trig === 1'b1) trig_seen++;
      end
      checks++; if (trig_seen != 0) begin errors++; $display("FAIL drop_no_trig: got %0d want 0", trig_seen); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_busy: got %b want 0", busy); end
   endtask

   initial begin
      test_reset;
      test_first_measure;
      test_back_to_back;
      test_no_echo;
      test_stuck_high;
      test_reset_mid_measure;
      test_enable_drop;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
